// File: rtl/div16_seq_pkg.sv
// Shared constants and state encoding for the sequential 16-bit divider.
package div16_seq_pkg;

    localparam int WIDTH = 16;

    // FSM encoding; the value 2'd3 is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value on the final (16th) restoring iteration.
    localparam logic [3:0] ITER_LAST = 4'd15;

    // Quotient reported when the divisor is zero.
    localparam logic [WIDTH-1:0] DIV0_QUOT = 16'hFFFF;

endpackage

// File: rtl/div16_seq_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a second
// level of group lookahead. Used by the divider as the trial subtractor.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    // Second-level lookahead: group carries come straight from group G/P and
    // cin, so no group carry depends on another group carry.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    // Per-group bit carries and group generate/propagate.
    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int B = 4 * k;
        assign c[B]   = gc[k];
        assign c[B+1] = g[B] | (p[B] & gc[k]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[k]);
        assign gg[k]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign gp[k]  = &p[B+3:B];
    end

    assign sum  = p ^ c;
    assign cout = gc[4];

endmodule

// File: rtl/div16_seq.sv
// Multi-cycle unsigned 16-bit restoring divider, one quotient bit per clock.
// Trial subtraction is S - D computed on cla16 as S + ~D + 1.
module div16_seq #(
    parameter int WIDTH = div16_seq_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    import div16_seq_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] d_r;      // captured divisor
    logic [WIDTH-1:0] q_r;      // working dividend / quotient shift register
    logic [WIDTH-1:0] r_r;      // working partial remainder
    logic [WIDTH-1:0] quo_r;    // visible results, separate from working regs
    logic [WIDTH-1:0] rem_r;
    logic             dz_r;

    logic [WIDTH-1:0] shft;     // low 16 bits of S = {R, Q[15]}
    logic [WIDTH-1:0] d_inv;
    logic [WIDTH-1:0] diff;
    logic             c_out;
    logic             ge;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             accept;
    logic             last;

    assign shft  = {r_r[WIDTH-2:0], q_r[WIDTH-1]};
    assign d_inv = ~d_r;

    cla16 u_sub (
        .a    (shft),
        .b    (d_inv),
        .cin  (1'b1),
        .sum  (diff),
        .cout (c_out)
    );

    // R[15] set means the 17-bit S is at least 2^16 > D, so the subtract
    // succeeds even though the adder only sees the low 16 bits.
    assign ge     = r_r[WIDTH-1] | c_out;
    assign r_nxt  = ge ? diff : shft;
    assign q_nxt  = {q_r[WIDTH-2:0], ge};
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == ITER_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = (divisor == '0) ? DONE : RUN;
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, restoring iteration and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            d_r   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            quo_r <= '0;
            rem_r <= '0;
            dz_r  <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            d_r  <= divisor;
            q_r  <= dividend;
            r_r  <= '0;
            dz_r <= 1'b0;
            if (divisor == '0) begin
                quo_r <= DIV0_QUOT;
                rem_r <= dividend;
                dz_r  <= 1'b1;
            end
        end else if (state == RUN) begin
            r_r <= r_nxt;
            q_r <= q_nxt;
            cnt <= cnt + 4'd1;
            if (last) begin
                quo_r <= q_nxt;
                rem_r <= r_nxt;
            end
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;
    assign div_zero  = dz_r;

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: expected results are queued at issue
// time and popped when done is observed.
module tb_div16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];

    div16_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the following posedge is the accepting edge E.
    // Returns at the negedge right after E.
    task automatic issue(input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        if (d == 16'd0) begin
            e.q = 16'hFFFF; e.r = a; e.dz = 1'b1;
        end else begin
            e.q = a / d; e.r = a % d; e.dz = 1'b0;
        end
        sb.push_back(e);
        start = 1'b1; dividend = a; divisor = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        e.a = 'x; e.d = 'x; e.q = 'x; e.r = 'x; e.dz = 1'bx;
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    // Counts negedges (including the current one) until done is seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        forever begin
            lat++;
            if (done === 1'b1) break;
            if (busy === 1'b1) bcnt++;
            if (lat >= 40) begin
                n_cmp++; n_err++;
                $display("FAIL wait_done: done not seen after %0d cycles, need <= 17", lat);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (quotient !== 16'h0) begin n_err++; $display("FAIL rst_quot: got %h want 0", quotient); end
        n_cmp++; if (remainder !== 16'h0) begin n_err++; $display("FAIL rst_rem: got %h want 0", remainder); end
        n_cmp++; if (div_zero !== 1'b0)  begin n_err++; $display("FAIL rst_dz: got %b want 0", div_zero); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        exp_t e; int lat, bc;
        @(negedge clk);
        issue(16'd100, 16'd7);
        wait_done(lat, bc);
        e = pop_exp();
        n_cmp++; if (lat != 17) begin n_err++; $display("FAIL basic_latency: got %0d want 17", lat); end
        n_cmp++; if (bc != 16)  begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 16", bc); end
        n_cmp++; if (quotient !== e.q)  begin n_err++; $display("FAIL basic_quot: got %0d want %0d", quotient, e.q); end
        n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL basic_rem: got %0d want %0d", remainder, e.r); end
        n_cmp++; if (div_zero !== e.dz) begin n_err++; $display("FAIL basic_dz: got %b want %b", div_zero, e.dz); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        n_cmp++; if (quotient !== 16'd14) begin n_err++; $display("FAIL basic_hold: got %0d want 14", quotient); end
    endtask

    task automatic test_r15;
        exp_t e; int lat, bc;
        @(negedge clk);
        issue(16'hFFFF, 16'h8001);
        wait_done(lat, bc);
        e = pop_exp();
        n_cmp++; if (quotient !== e.q)  begin n_err++; $display("FAIL r15_quot: got %h want %h", quotient, e.q); end
        n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL r15_rem: got %h want %h", remainder, e.r); end
        issue(16'hFFFF, 16'h0001);
        wait_done(lat, bc);
        e = pop_exp();
        n_cmp++; if (quotient !== e.q)  begin n_err++; $display("FAIL div1_quot: got %h want %h", quotient, e.q); end
        n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL div1_rem: got %h want %h", remainder, e.r); end
    endtask

    task automatic test_div0;
        exp_t e; int lat, bc;
        @(negedge clk);
        issue(16'h1234, 16'h0000);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL div0_busy: got %b want 0", busy); end
        wait_done(lat, bc);
        e = pop_exp();
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL div0_latency: got %0d want 1", lat); end
        n_cmp++; if (quotient !== e.q)  begin n_err++; $display("FAIL div0_quot: got %h want %h", quotient, e.q); end
        n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL div0_rem: got %h want %h", remainder, e.r); end
        n_cmp++; if (div_zero !== e.dz) begin n_err++; $display("FAIL div0_dz: got %b want %b", div_zero, e.dz); end
    endtask

    task automatic test_back_to_back;
        exp_t e; int lat, bc;
        @(negedge clk);
        issue(16'd500, 16'd3);
        repeat (4) @(negedge clk);
        // Start during RUN cycle 5 must be ignored.
        start = 1'b1; dividend = 16'd9; divisor = 16'd2;
        @(negedge clk);
        start = 1'b0; dividend = '0; divisor = '0;
        wait_done(lat, bc);
        e = pop_exp();
        n_cmp++; if (lat != 12) begin n_err++; $display("FAIL ignore_latency: got %0d want 12", lat); end
        n_cmp++; if (quotient !== e.q)  begin n_err++; $display("FAIL ignore_quot: got %0d want %0d", quotient, e.q); end
        n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL ignore_rem: got %0d want %0d", remainder, e.r); end
        // Restart straight from the DONE cycle.
        issue(16'd9, 16'd2);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy); end
        n_cmp++; if (quotient !== 16'd166) begin n_err++; $display("FAIL b2b_hold: got %0d want 166", quotient); end
        wait_done(lat, bc);
        e = pop_exp();
        n_cmp++; if (lat != 17) begin n_err++; $display("FAIL b2b_latency: got %0d want 17", lat); end
        n_cmp++; if (quotient !== e.q)  begin n_err++; $display("FAIL b2b_quot: got %0d want %0d", quotient, e.q); end
        n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL b2b_rem: got %0d want %0d", remainder, e.r); end
    endtask

    task automatic test_async_reset;
        exp_t e; int lat, bc, seen;
        @(negedge clk);
        issue(16'd500, 16'd3);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL arst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL arst_done: got %b want 0", done); end
        n_cmp++; if (quotient !== 16'h0)  begin n_err++; $display("FAIL arst_quot: got %h want 0", quotient); end
        n_cmp++; if (remainder !== 16'h0) begin n_err++; $display("FAIL arst_rem: got %h want 0", remainder); end
        n_cmp++; if (div_zero !== 1'b0)   begin n_err++; $display("FAIL arst_dz: got %b want 0", div_zero); end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL arst_abandon: got %0d active cycles want 0", seen); end
        issue(16'd7, 16'd7);
        wait_done(lat, bc);
        e = pop_exp();
        n_cmp++; if (quotient !== e.q)  begin n_err++; $display("FAIL arst_after_quot: got %0d want %0d", quotient, e.q); end
        n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL arst_after_rem: got %0d want %0d", remainder, e.r); end
    endtask

    task automatic test_random;
        exp_t e; int lat, bc;
        logic [15:0] a, d;
        logic [31:0] prod;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            d = (i % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
            issue(a, d);
            wait_done(lat, bc);
            e = pop_exp();
            prod = 32'(quotient) * 32'(e.d) + 32'(remainder);
            n_cmp++; if (quotient !== e.q || remainder !== e.r) begin
                n_err++; $display("FAIL rnd_result %h/%h: got %h r %h want %h r %h", e.a, e.d, quotient, remainder, e.q, e.r);
            end
            n_cmp++; if (prod !== 32'(e.a)) begin
                n_err++; $display("FAIL rnd_identity %h/%h: got q*d+r=%h want %h", e.a, e.d, prod, e.a);
            end
            n_cmp++; if (!(remainder < e.d)) begin
                n_err++; $display("FAIL rnd_rem_lt_div %h/%h: got rem %h want < %h", e.a, e.d, remainder, e.d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_r15();
        test_div0();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
